branch_unit: RTL and testbench
==============================

// Module: branch_unit
// PURPOSE
//  Registered branch resolution plus bimodal predictor for the RISCV core. Fetch reads a per-PC
//  prediction; EX resolves BRANCH/JAL/JALR one cycle later and trains the table. It flags a
//  mispredict with a redirect PC. Sits between the EX operand muxes and the fetch PC mux.
// PARAMETERS
//  XLEN         32  datapath/PC width
//  BHT_ENTRIES  64  predictor entries, power of 2, >=2; index = pc[$clog2(BHT_ENTRIES)+1:2]
//  CNT_BITS     2   saturating counter width, >=1; MSB=1 means predict taken
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous reset, active-high
//  fetch_pc     in   XLEN  PC being fetched
//  fetch_pred   out  1     combinational prediction for fetch_pc (JAL/JALR not distinguished)
//  ex_valid     in   1     EX presents an instruction
//  ex_ready     out  1     = !res_valid || res_ready
//  ex_optype    in   op_type (RISCV pkg)  BRANCH/JAL/JALR; others resolve not-taken, no training
//  ex_funct3    in   3     branch condition
//  ex_op1/op2   in   XLEN  rs1/rs2 values
//  ex_pc        in   XLEN  instruction PC
//  ex_imm       in   XLEN  sign-extended immediate
//  ex_pred      in   1     prediction carried down the pipe from fetch
//  flush        in   1     kill accepted-this-cycle and held result
//  res_valid    out  1     result register valid
//  res_ready    in   1     consumer accepts result
//  res_taken    out  1     resolved direction
//  res_mispred  out  1     res_taken != carried prediction, or JALR (always redirect)
//  res_target   out  XLEN  redirect PC: taken ? target : pc+4
//  stat_branches/stat_mispreds  out 32  see CONFIGURATION
// BEHAVIOUR
//  - Reset: res_valid=0, res_taken=0, res_mispred=0, res_target=0, all counters = 2^(CNT_BITS-1)-1
//    (weakly not-taken), stats=0. A reset mid-transfer drops the held result; no table write that cycle.
//  - Accept when ex_valid && ex_ready && !flush; result registered next edge (latency 1).
//    res_* are stable while res_valid && !res_ready.
//  - Conditions: BEQ 0 ==, BNE 1 !=, BLT 4 signed <, BGE 5 signed >=, BLTU 6 <, BGEU 7 >=;
//    funct3 2/3 -> not-taken, no mispred, no training. JAL/JALR always taken.
//  - Target: BRANCH/JAL = ex_pc+ex_imm; JALR = (ex_op1+ex_imm) & ~1. Modulo 2^XLEN, wrap silent.
//    Fall-through = ex_pc+4, also wraps.
//  - Training on accept of a valid BRANCH only: taken -> counter+1 saturating at max; not-taken ->
//    counter-1 saturating at 0. Write lands on the accept edge.
//  - Same-cycle fetch read and training write to one index: fetch_pred returns the pre-write value.
//  - flush: res_valid cleared next edge; an instruction offered in the flush cycle is not
//    accepted, not trained, not counted. flush wins over res_ready.
//  - res_ready=0 with res_valid=1: ex_ready=0, no training, no stat increment (no double counting).
// CONFIGURATION
//  - BRANCH_UNIT_STATS_EN defined: stat_branches counts accepted BRANCH/JAL/JALR;
//    stat_mispreds counts accepted with mispredict. 32-bit, wrap at 2^32. Cleared by rst.
//  - Not defined: both stat ports tied to 0; no counter flops.
// STRUCTURE
//  - RISCV package: add BR_BEQ..BR_BGEU funct3 localparams; keep op_type in the package.
//  - Sub-module bht_table: BHT_ENTRIES x CNT_BITS array, 1 async read port, 1 sync write port
//    with saturating update, reset init. Condition/target compare logic stays in branch_unit.
// TESTING
//  1. rst=1 two cycles, then fetch_pc=0x100 -> fetch_pred=0; res_valid=0; stats=0.
//  2. BRANCH BEQ op1=op2=5, pc=0x100, imm=0x20, pred=0 -> next cycle res_taken=1,
//     res_mispred=1, res_target=0x120; entry 0x100 goes 01->10; fetch_pred(0x100)=1.
//  3. BLT op1=0xFFFFFFFF, op2=1 -> taken; BLTU same operands -> not-taken, res_target=pc+4.
//  4. JALR op1=0x1003, imm=0x4 -> res_target=0x1006, res_mispred=1, table untouched.
//  5. Four taken BRANCH at pc=0x200 -> counter saturates at 11; four not-taken -> 00, no wrap.
//  6. res_ready=0 three cycles, ex_valid held -> ex_ready=0, outputs stable, stat_branches
//     +1 only; then flush with ex_valid=1 -> res_valid=0 next edge, nothing trained.

Source files
------------

// File: rtl/branch_unit_pkg.sv
// Shared RISCV control-flow definitions: operation classes and branch funct3 encodings.
package branch_unit_pkg;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JAL    = 3'd2,
        OP_JALR   = 3'd3,
        OP_LOAD   = 3'd4,
        OP_STORE  = 3'd5
    } op_type;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLT  = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;
    localparam logic [2:0] BR_BGEU = 3'd7;

    function automatic logic is_jump(input op_type op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_unit_bht_table.sv
// Bimodal history table: saturating counters, one async read port, one sync training port.
module bht_table #(
    parameter int ENTRIES  = 64,
    parameter int CNT_BITS = 2,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [CNT_BITS-1:0] rd_cnt,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic                wr_taken
);

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    logic [CNT_BITS-1:0] cnt_q [ENTRIES];
    logic [CNT_BITS-1:0] wr_cur;

    assign rd_cnt = cnt_q[rd_idx];
    assign wr_cur = cnt_q[wr_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (wr_en) begin
            if (wr_taken && (wr_cur != CNT_MAX)) begin
                cnt_q[wr_idx] <= wr_cur + 1'b1;
            end else if (!wr_taken && (wr_cur != '0)) begin
                cnt_q[wr_idx] <= wr_cur - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Registered branch resolution with bimodal prediction and redirect generation.
// Optional statistics counters are built when BRANCH_UNIT_STATS_EN is defined.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_BITS    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_pred,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  op_type          ex_optype,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_op1,
    input  logic [XLEN-1:0] ex_op2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic            res_mispred,
    output logic [XLEN-1:0] res_target,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispreds
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic                accept;
    logic                is_branch;
    logic                cond_valid;
    logic                cond_taken;
    logic                taken;
    logic                mispred;
    logic                train;
    logic [XLEN-1:0]     target;
    logic [XLEN-1:0]     jump_target;
    logic [CNT_BITS-1:0] fetch_cnt;
    logic                unused_fetch_bits;

    assign ex_ready  = !res_valid || res_ready;
    assign accept    = ex_valid && ex_ready && !flush;
    assign is_branch = (ex_optype == OP_BRANCH);

    always_comb begin
        cond_valid = 1'b1;
        cond_taken = 1'b0;
        case (ex_funct3)
            BR_BEQ:  cond_taken = (ex_op1 == ex_op2);
            BR_BNE:  cond_taken = (ex_op1 != ex_op2);
            BR_BLT:  cond_taken = ($signed(ex_op1) <  $signed(ex_op2));
            BR_BGE:  cond_taken = ($signed(ex_op1) >= $signed(ex_op2));
            BR_BLTU: cond_taken = (ex_op1 <  ex_op2);
            BR_BGEU: cond_taken = (ex_op1 >= ex_op2);
            default: cond_valid = 1'b0;
        endcase
    end

    // Undefined funct3 and non-control ops fall through silently: no redirect, no training.
    always_comb begin
        taken   = 1'b0;
        mispred = 1'b0;
        if (is_branch && cond_valid) begin
            taken   = cond_taken;
            mispred = (cond_taken != ex_pred);
        end else if (ex_optype == OP_JAL) begin
            taken   = 1'b1;
            mispred = !ex_pred;
        end else if (ex_optype == OP_JALR) begin
            taken   = 1'b1;
            mispred = 1'b1;
        end
    end

    assign jump_target = (ex_optype == OP_JALR)
                       ? ((ex_op1 + ex_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                       : (ex_pc + ex_imm);
    assign target = taken ? jump_target : (ex_pc + XLEN'(4));

    assign train = accept && is_branch && cond_valid && !rst;

    bht_table #(
        .ENTRIES  (BHT_ENTRIES),
        .CNT_BITS (CNT_BITS),
        .IDX_W    (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (fetch_pc[IDX_W+1:2]),
        .rd_cnt   (fetch_cnt),
        .wr_en    (train),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign fetch_pred        = fetch_cnt[CNT_BITS-1];
    assign unused_fetch_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_mispred <= 1'b0;
            res_target  <= '0;
        end else begin
            if (flush) begin
                res_valid <= 1'b0;
            end else if (accept) begin
                res_valid <= 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (accept) begin
                res_taken   <= taken;
                res_mispred <= mispred;
                res_target  <= target;
            end
        end
    end

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispreds_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispreds_q <= '0;
        end else if (accept && (is_branch || is_jump(ex_optype))) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            if (mispred) begin
                stat_mispreds_q <= stat_mispreds_q + 32'd1;
            end
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispreds = stat_mispreds_q;
`else
    assign stat_branches = '0;
    assign stat_mispreds = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: vector table for resolution, hand sequences for training/stall/flush/reset.
module tb_branch_unit;
    import branch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_pred;
    logic        ex_valid;
    logic        ex_ready;
    op_type      ex_optype;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_op1, ex_op2, ex_pc, ex_imm;
    logic        ex_pred;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic        res_taken;
    logic        res_mispred;
    logic [31:0] res_target;
    logic [31:0] stat_branches, stat_mispreds;

`ifdef BRANCH_UNIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    branch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_pc      (fetch_pc),
        .fetch_pred    (fetch_pred),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_optype     (ex_optype),
        .ex_funct3     (ex_funct3),
        .ex_op1        (ex_op1),
        .ex_op2        (ex_op2),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_pred       (ex_pred),
        .flush         (flush),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_taken     (res_taken),
        .res_mispred   (res_mispred),
        .res_target    (res_target),
        .stat_branches (stat_branches),
        .stat_mispreds (stat_mispreds)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_type      op;
        logic [2:0]  f3;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        exp_taken;
        logic        exp_mispred;
        logic [31:0] exp_target;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int n_pass  = 0;
    int n_total = 0;
    int exp_br  = 0;
    int exp_mp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_type op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred);
        ex_optype = op;
        ex_funct3 = f3;
        ex_op1    = a;
        ex_op2    = b;
        ex_pc     = pc;
        ex_imm    = imm;
        ex_pred   = pred;
        ex_valid  = 1'b1;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, " stat_branches"}, stat_branches, STATS ? 32'(exp_br) : 32'd0);
        chk({tag, " stat_mispreds"}, stat_mispreds, STATS ? 32'(exp_mp) : 32'd0);
    endtask

    task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
        fetch_pc = pc;
        #1;
        chk(name, 32'(fetch_pred), 32'(exp));
    endtask

    initial begin
        logic sat_exp [9];
        sat_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        //          op         f3    op1           op2           pc            imm           pr  tk  mp  target
        vecs[0]  = '{OP_BRANCH, 3'd1, 32'd3,        32'd3,        32'h0000_0344, 32'h10,       1, 0, 1, 32'h0000_0348};
        vecs[1]  = '{OP_BRANCH, 3'd1, 32'd3,        32'd4,        32'h0000_0348, 32'hFFFF_FFF0, 1, 1, 0, 32'h0000_0338};
        vecs[2]  = '{OP_BRANCH, 3'd4, 32'hFFFF_FFFF, 32'd1,       32'h0000_034C, 32'h8,        0, 1, 1, 32'h0000_0354};
        vecs[3]  = '{OP_BRANCH, 3'd6, 32'hFFFF_FFFF, 32'd1,       32'h0000_0350, 32'h8,        0, 0, 0, 32'h0000_0354};
        vecs[4]  = '{OP_BRANCH, 3'd5, 32'd1,        32'hFFFF_FFFF, 32'h0000_0354, 32'h40,      1, 1, 0, 32'h0000_0394};
        vecs[5]  = '{OP_BRANCH, 3'd7, 32'hFFFF_FFFF, 32'd1,       32'h0000_0358, 32'h4,        0, 1, 1, 32'h0000_035C};
        vecs[6]  = '{OP_BRANCH, 3'd7, 32'd1,        32'd2,        32'h0000_035C, 32'h4,        1, 0, 1, 32'h0000_0360};
        vecs[7]  = '{OP_BRANCH, 3'd0, 32'd1,        32'd2,        32'h0000_0360, 32'h40,       0, 0, 0, 32'h0000_0364};
        vecs[8]  = '{OP_BRANCH, 3'd2, 32'd1,        32'd1,        32'h0000_0364, 32'h40,       1, 0, 0, 32'h0000_0368};
        vecs[9]  = '{OP_JAL,    3'd0, 32'd0,        32'd0,        32'h0000_0368, 32'h100,      1, 1, 0, 32'h0000_0468};
        vecs[10] = '{OP_JAL,    3'd0, 32'd0,        32'd0,        32'hFFFF_FFF0, 32'h20,       0, 1, 1, 32'h0000_0010};
        vecs[11] = '{OP_BRANCH, 3'd0, 32'd1,        32'd2,        32'hFFFF_FFFC, 32'h40,       0, 0, 0, 32'h0000_0000};
        vecs[12] = '{OP_ALU,    3'd0, 32'd5,        32'd5,        32'h0000_0370, 32'h40,       0, 0, 0, 32'h0000_0374};
        vecs[13] = '{OP_JALR,   3'd0, 32'h1003,     32'd0,        32'h0000_010C, 32'h4,        1, 1, 1, 32'h0000_1006};

        rst = 1'b1; flush = 1'b0; res_ready = 1'b1; fetch_pc = 32'h100;
        ex_valid = 1'b0; ex_optype = OP_ALU; ex_funct3 = 3'd0;
        ex_op1 = '0; ex_op2 = '0; ex_pc = '0; ex_imm = '0; ex_pred = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_pred("reset fetch_pred", 32'h100, 1'b0);
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk("reset res_target", res_target, 32'd0);
        chk_stats("reset");

        // BEQ taken against a not-taken prediction, same-cycle read sees old counter
        drive(OP_BRANCH, BR_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        #1;
        chk("beq same-cycle fetch_pred", 32'(fetch_pred), 32'd0);
        chk("beq ex_ready", 32'(ex_ready), 32'd1);
        tick();
        ex_valid = 1'b0;
        exp_br++; exp_mp++;
        chk("beq res_valid", 32'(res_valid), 32'd1);
        chk("beq res_taken", 32'(res_taken), 32'd1);
        chk("beq res_mispred", 32'(res_mispred), 32'd1);
        chk("beq res_target", res_target, 32'h120);
        chk_pred("beq trained fetch_pred", 32'h100, 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].op1, vecs[i].op2, vecs[i].pc, vecs[i].imm, vecs[i].pred);
            tick();
            ex_valid = 1'b0;
            if (vecs[i].op != OP_ALU) exp_br++;
            if (vecs[i].exp_mispred) exp_mp++;
            chk($sformatf("vec%0d res_valid", i), 32'(res_valid), 32'd1);
            chk($sformatf("vec%0d res_taken", i), 32'(res_taken), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d res_mispred", i), 32'(res_mispred), 32'(vecs[i].exp_mispred));
            chk($sformatf("vec%0d res_target", i), res_target, vecs[i].exp_target);
        end
        chk_pred("jalr table untouched", 32'h10C, 1'b0);
        chk_stats("vectors");

        // Saturation at pc 0x200 (shares index 0 with 0x100, counter starts at 10)
        for (int i = 0; i < 9; i++) begin
            logic tk;
            tk = (i < 4) || (i == 8);
            drive(OP_BRANCH, BR_BEQ, 32'd0, tk ? 32'd0 : 32'd1, 32'h200, 32'h8, 1'b0);
            tick();
            ex_valid = 1'b0;
            exp_br++;
            if (tk) exp_mp++;
            chk_pred($sformatf("sat step%0d fetch_pred", i), 32'h200, sat_exp[i]);
        end
        chk_stats("saturate");

        // Backpressure: hold one result, offer another, then flush
        tick();
        chk("idle res_valid", 32'(res_valid), 32'd0);
        drive(OP_BRANCH, BR_BNE, 32'd1, 32'd2, 32'h120, 32'h40, 1'b0);
        tick();
        exp_br++; exp_mp++;
        res_ready = 1'b0;
        drive(OP_BRANCH, BR_BEQ, 32'd7, 32'd7, 32'h124, 32'h4, 1'b1);
        #1;
        chk("stall ex_ready", 32'(ex_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d res_valid", i), 32'(res_valid), 32'd1);
            chk($sformatf("stall%0d res_taken", i), 32'(res_taken), 32'd1);
            chk($sformatf("stall%0d res_mispred", i), 32'(res_mispred), 32'd1);
            chk($sformatf("stall%0d res_target", i), res_target, 32'h160);
            chk($sformatf("stall%0d ex_ready", i), 32'(ex_ready), 32'd0);
        end
        chk_stats("stall");
        flush = 1'b1;
        tick();
        chk("flush res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("flush blocks accept", 32'(res_valid), 32'd0);
        flush = 1'b0;
        ex_valid = 1'b0;
        res_ready = 1'b1;
        chk_pred("flush no training", 32'h124, 1'b0);
        chk_stats("flush");

        // Reset while a result is held
        drive(OP_BRANCH, BR_BEQ, 32'd3, 32'd3, 32'h128, 32'h80, 1'b0);
        tick();
        ex_valid = 1'b0;
        res_ready = 1'b0;
        chk("pre-reset res_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_br = 0; exp_mp = 0;
        chk("mid reset res_valid", 32'(res_valid), 32'd0);
        chk("mid reset res_target", res_target, 32'd0);
        chk("mid reset res_taken", 32'(res_taken), 32'd0);
        chk_pred("mid reset table init", 32'h348, 1'b0);
        chk_stats("mid reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
